chirp_sample_fetch: RTL and testbench
=====================================

// Module: chirp_sample_fetch
// PURPOSE
//  Upstream feeder of the chirp processing pipeline: reads one frame of raw chirp samples from sample RAM
//  and streams it as 128-bit words with valid/last framing into i_x0/i_x0_valid/i_x0_last of that pipeline.
//  Owns RAM addressing (per-chirp base/stride), read-latency alignment, RAM-grant stalls and frame completion.
//  The downstream stage has no backpressure, so this block decides when words flow.
// PARAMETERS
//  READ_RAM_WIDTH  128  RAM word / output data width (8 x 16-bit samples)
//  ADDR_WIDTH      12   RAM word-address width
//  RAM_RD_LATENCY  2    cycles from o_ram_rd_en to valid i_ram_rdata (>=1)
//  SMP_CNT_WIDTH   13   width of words-per-chirp count
//  CHP_CNT_WIDTH   10   width of chirps-per-frame count
// PORTS
//  clk           in   1               clock
//  rst           in   1               asynchronous reset, active-high
//  i_start       in   1               frame start pulse; sampled only in IDLE
//  i_base_addr   in   ADDR_WIDTH      word address of chirp 0, word 0
//  i_chp_stride  in   ADDR_WIDTH      address step between chirp starts
//  i_smp_cnt     in   SMP_CNT_WIDTH   words per chirp
//  i_chp_cnt     in   CHP_CNT_WIDTH   chirps per frame
//  i_ram_gnt     in   1               RAM port grant; read issued only when high
//  o_ram_rd_en   out  1               RAM read strobe
//  o_ram_addr    out  ADDR_WIDTH      RAM read address
//  i_ram_rdata   in   READ_RAM_WIDTH  RAM read data, RAM_RD_LATENCY after o_ram_rd_en
//  o_x0          out  READ_RAM_WIDTH  sample word to chirp processing
//  o_x0_valid    out  1               o_x0 valid
//  o_x0_last     out  1               last word of current chirp (qualified by o_x0_valid)
//  o_frame_done  out  1               one-cycle pulse after last word of frame leaves
//  o_busy        out  1               high from accepted start until o_frame_done
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, read pipeline flushed. Reset mid-frame aborts; no done pulse.
//  - Config (base, stride, smp_cnt, chp_cnt) registered on accepted i_start; later changes ignored until next frame.
//  - FSM: IDLE -> RUN on i_start (o_busy=1 next cycle). RUN issues reads; after final word issued -> DRAIN.
//    DRAIN waits until read pipeline empty -> DONE. DONE: o_frame_done=1 one cycle -> IDLE (o_busy=0 same cycle).
//  - i_start with i_smp_cnt==0 or i_chp_cnt==0: no reads, IDLE -> DONE directly, done pulse 2 cycles after start.
//  - i_start while not IDLE: ignored.
//  - RUN read issue: o_ram_rd_en = i_ram_gnt (registered decision, 1 read/cycle max).
//    o_ram_addr = base + chp_idx*stride + word_idx, modulo 2^ADDR_WIDTH (wrap silently).
//    word_idx 0..smp_cnt-1; at smp_cnt-1 wraps to 0 and chp_idx increments; chp_stride*chp_idx via accumulator, no multiplier.
//  - i_ram_gnt low: no read, address/counters hold; in-flight reads still complete and emerge.
//  - Alignment: rd_en and a last tag (word_idx==smp_cnt-1) travel through a RAM_RD_LATENCY-deep shift register;
//    o_x0_valid/o_x0_last are their outputs, o_x0 registers i_ram_rdata when tagged valid (one output reg stage:
//    total latency rd_en -> o_x0_valid = RAM_RD_LATENCY+1). o_x0 holds previous value when not valid.
//  - o_x0_valid has no gaps except those caused by i_ram_gnt low (or gap feature). Words never dropped or duplicated.
//  - o_frame_done asserts the cycle after the o_x0_valid carrying the frame's final o_x0_last.
// CONFIGURATION
//  CHIRP_FETCH_GAP_EN defined: extra input i_gap_cyc [7:0] (registered on start); after issuing each chirp's last
//   read (except the final chirp) RUN inserts i_gap_cyc idle cycles with o_ram_rd_en=0 before the next chirp,
//   giving downstream last/diff logic inter-chirp spacing; gap counter does not count while stalled on grant.
//  Undefined: no i_gap_cyc port; chirps issued back-to-back.
// TESTING
//  - Reset: rst=1 mid-stream -> all outputs 0 same cycle (async), no o_frame_done; next start runs normally.
//  - Basic: base=0x010, stride=0x040, smp=4, chp=3, gnt=1 -> addrs 010..013,050..053,090..093; 12 valid words back-to-back,
//    o_x0_last on words 4,8,12; o_x0 equals RAM model data; o_frame_done one cycle after word 12.
//  - Stall: same config, gnt low 5 cycles mid-chirp-1 -> exactly 5-cycle valid gap, same 12 words in order, no duplicates.
//  - Wrap: base=0xFFE, smp=4, chp=1 -> addrs FFE,FFF,000,001; last on 4th word.
//  - Degenerate: smp=0 -> no o_ram_rd_en, o_frame_done 2 cycles after start; start while busy -> ignored, one done only.
//  - Gap (CHIRP_FETCH_GAP_EN, gap=3, smp=2, chp=2): rd_en pattern 1,1,0,0,0,1,1; no gap after final chirp.

Source files
------------

// File: rtl/chirp_sample_fetch.sv
// chirp_sample_fetch: streams one frame of chirp samples from sample RAM as framed 128-bit words.
// Define CHIRP_FETCH_GAP_EN to add i_gap_cyc idle cycles between chirps.
module chirp_sample_fetch #(
  parameter int READ_RAM_WIDTH = 128,
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_RD_LATENCY = 2,
  parameter int SMP_CNT_WIDTH  = 13,
  parameter int CHP_CNT_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [ADDR_WIDTH-1:0]     i_chp_stride,
  input  logic [SMP_CNT_WIDTH-1:0]  i_smp_cnt,
  input  logic [CHP_CNT_WIDTH-1:0]  i_chp_cnt,
`ifdef CHIRP_FETCH_GAP_EN
  input  logic [7:0]                i_gap_cyc,
`endif
  input  logic                      i_ram_gnt,
  output logic                      o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]     o_ram_addr,
  input  logic [READ_RAM_WIDTH-1:0] i_ram_rdata,
  output logic [READ_RAM_WIDTH-1:0] o_x0,
  output logic                      o_x0_valid,
  output logic                      o_x0_last,
  output logic                      o_frame_done,
  output logic                      o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0]     r_stride, r_addr, r_chp_base;
  logic [SMP_CNT_WIDTH-1:0]  r_smp_cnt, r_word_idx;
  logic [CHP_CNT_WIDTH-1:0]  r_chp_cnt, r_chp_idx;
  logic [RAM_RD_LATENCY-1:0] r_vld_sr, r_last_sr, w_vld_lo;
  logic [READ_RAM_WIDTH-1:0] r_x0;
  logic                      r_x0_valid, r_x0_last, r_done;
  logic                      w_accept, w_rd_en, w_word_last, w_chp_last, w_gap_wait;
  assign w_accept    = r_state == S_IDLE && i_start;
  assign w_rd_en     = r_state == S_RUN && !w_gap_wait && i_ram_gnt;
  assign w_word_last = r_word_idx == r_smp_cnt - 1'b1;
  assign w_chp_last  = r_chp_idx == r_chp_cnt - 1'b1;
  // Everything below the output tap drained means the final word is the one now leaving the RAM.
  assign w_vld_lo    = r_vld_sr << 1;
`ifdef CHIRP_FETCH_GAP_EN
  logic [7:0] r_gap_cyc, r_gap_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_gap_cyc <= '0;
      r_gap_cnt <= '0;
    end else if (w_accept) begin
      r_gap_cyc <= i_gap_cyc;
      r_gap_cnt <= '0;
    end else if (w_rd_en && w_word_last)
      r_gap_cnt <= w_chp_last ? 8'd0 : r_gap_cyc;
    else if (w_gap_wait && i_ram_gnt)
      r_gap_cnt <= r_gap_cnt - 8'd1;
  assign w_gap_wait = r_gap_cnt != 8'd0;
`else
  assign w_gap_wait = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_smp_cnt == '0 || i_chp_cnt == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_rd_en && w_word_last && w_chp_last) w_next = S_DRAIN;
      S_DRAIN: if (w_vld_lo == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
  end
  // The chirp base accumulates the stride so no multiplier is needed.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_stride   <= '0;
      r_smp_cnt  <= '0;
      r_chp_cnt  <= '0;
      r_addr     <= '0;
      r_chp_base <= '0;
      r_word_idx <= '0;
      r_chp_idx  <= '0;
    end else if (w_accept) begin
      r_stride   <= i_chp_stride;
      r_smp_cnt  <= i_smp_cnt;
      r_chp_cnt  <= i_chp_cnt;
      r_addr     <= i_base_addr;
      r_chp_base <= i_base_addr;
      r_word_idx <= '0;
      r_chp_idx  <= '0;
    end else if (w_rd_en && w_word_last) begin
      r_word_idx <= '0;
      r_chp_idx  <= r_chp_idx + 1'b1;
      r_chp_base <= r_chp_base + r_stride;
      r_addr     <= r_chp_base + r_stride;
    end else if (w_rd_en) begin
      r_word_idx <= r_word_idx + 1'b1;
      r_addr     <= r_addr + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vld_sr   <= '0;
      r_last_sr  <= '0;
      r_x0       <= '0;
      r_x0_valid <= 1'b0;
      r_x0_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_vld_sr   <= (r_vld_sr << 1) | RAM_RD_LATENCY'(w_rd_en);
      r_last_sr  <= (r_last_sr << 1) | RAM_RD_LATENCY'(w_rd_en && w_word_last);
      r_x0_valid <= r_vld_sr[RAM_RD_LATENCY-1];
      r_x0_last  <= r_vld_sr[RAM_RD_LATENCY-1] && r_last_sr[RAM_RD_LATENCY-1];
      r_done     <= r_state == S_DONE;
      if (r_vld_sr[RAM_RD_LATENCY-1]) r_x0 <= i_ram_rdata;
    end
  assign o_ram_rd_en  = w_rd_en;
  assign o_ram_addr   = r_addr;
  assign o_x0         = r_x0;
  assign o_x0_valid   = r_x0_valid;
  assign o_x0_last    = r_x0_last;
  assign o_frame_done = r_done;
  assign o_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_chirp_sample_fetch.sv
// tb_chirp_sample_fetch: scoreboard bench; frame model pushes expected reads/words, negedge monitor pops and compares.
module tb_chirp_sample_fetch;
  localparam int AW = 12, DW = 128, L = 2, SW = 13, CW = 10;
  logic clk = 0, rst = 1, i_start = 0, i_ram_gnt = 0;
  logic [AW-1:0] i_base_addr = '0, i_chp_stride = '0;
  logic [SW-1:0] i_smp_cnt = '0;
  logic [CW-1:0] i_chp_cnt = '0;
  logic [DW-1:0] i_ram_rdata, o_x0, junk = '0, prev_x0 = '0;
  logic o_ram_rd_en, o_x0_valid, o_x0_last, o_frame_done, o_busy;
  logic [AW-1:0] o_ram_addr;
`ifdef CHIRP_FETCH_GAP_EN
  logic [7:0] gap_cyc = '0;
`endif
  chirp_sample_fetch #(.READ_RAM_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(L),
    .SMP_CNT_WIDTH(SW), .CHP_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr), .i_chp_stride(i_chp_stride),
    .i_smp_cnt(i_smp_cnt), .i_chp_cnt(i_chp_cnt),
`ifdef CHIRP_FETCH_GAP_EN
    .i_gap_cyc(gap_cyc),
`endif
    .i_ram_gnt(i_ram_gnt), .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr), .i_ram_rdata(i_ram_rdata),
    .o_x0(o_x0), .o_x0_valid(o_x0_valid), .o_x0_last(o_x0_last), .o_frame_done(o_frame_done), .o_busy(o_busy));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {8{a[3:0] ^ 4'h6, a}};
  endfunction
  // RAM model: fixed read latency L, garbage on the bus when no read is returning
  logic [L-1:0] ram_v = '0;
  logic [AW-1:0] ram_a [L];
  always @(posedge clk) begin
    ram_v <= {ram_v[L-2:0], o_ram_rd_en};
    ram_a[0] <= o_ram_addr;
    for (int i = 1; i < L; i++) ram_a[i] <= ram_a[i-1];
    junk <= {$urandom, $urandom, $urandom, $urandom};
  end
  assign i_ram_rdata = ram_v[L-1] ? ram_word(ram_a[L-1]) : junk;
  typedef struct packed { logic [DW-1:0] d; logic last; logic fin; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [AW-1:0] addr_q[$];
  int n_cmp = 0, n_bad = 0, exp_done_cyc = -1, done_cnt = 0, d_base = 0, first_v = -1, last_v = -1;
  bit gnt_rand = 0, gnt_force = 1;
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  initial forever begin
    @(posedge clk); #2;
    i_ram_gnt = gnt_rand ? ($urandom_range(9) < 7) : gnt_force;
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_ram_rd_en) begin
        check("rd_without_gnt", i_ram_gnt, 1);
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", o_ram_addr, addr_q.pop_front());
      end
      if (o_x0_valid) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("x0_data", o_x0, e.d);
          check("x0_last", o_x0_last, e.last);
          if (e.fin) exp_done_cyc = cyc + 1;
        end
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end else begin
        check("x0_hold", o_x0, prev_x0);
        check("last_unqualified", o_x0_last, 0);
      end
      if (o_frame_done) begin
        done_cnt++;
        check("done_cycle", cyc, exp_done_cyc);
        check("busy_at_done", o_busy, 0);
        exp_done_cyc = -1;
      end else if (cyc == exp_done_cyc) check("done_missing", 0, 1);
    end
    prev_x0 = o_x0;
  end
  task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] s, input int smp, input int chp);
    logic [AW-1:0] a;
    i_base_addr = b; i_chp_stride = s; i_smp_cnt = SW'(smp); i_chp_cnt = CW'(chp);
    for (int c = 0; c < chp; c++)
      for (int w = 0; w < smp; w++) begin
        a = AW'(int'(b) + c * int'(s) + w);
        addr_q.push_back(a);
        exp_q.push_back('{d: ram_word(a), last: (w == smp - 1), fin: (c == chp - 1 && w == smp - 1)});
      end
    if (smp == 0 || chp == 0) exp_done_cyc = cyc + 2;
    d_base = done_cnt;
    first_v = -1;
    i_start = 1;
    @(posedge clk); #1;
    i_start = 0;
    i_base_addr = AW'($urandom); i_chp_stride = AW'($urandom); i_smp_cnt = SW'($urandom); i_chp_cnt = CW'($urandom);
    check("busy_after_start", o_busy, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400 && done_cnt == d_base; i++) @(posedge clk);
    #1;
    check("frame_done_seen", done_cnt - d_base, 1);
    check("words_outstanding", exp_q.size(), 0);
    check("reads_outstanding", addr_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", done_cnt - d_base, 1);
    check("idle_after_done", o_busy, 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_rd_en", o_ram_rd_en, 0);
    check("rst_addr", o_ram_addr, 0);
    check("rst_x0", o_x0, 0);
    check("rst_valid", o_x0_valid, 0);
    check("rst_last", o_x0_last, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_busy", o_busy, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 0;
    @(posedge clk); #1;
    // basic frame plus an ignored start while busy
    start_frame(12'h010, 12'h040, 4, 3);
    repeat (3) @(posedge clk);
    #1;
    i_start = 1; i_smp_cnt = 5; i_chp_cnt = 2;
    @(posedge clk); #1;
    i_start = 0;
    wait_done();
    check("basic_span", last_v - first_v, 11);
    // grant stall mid chirp 1: valid stream gets exactly a 5-cycle hole
    start_frame(12'h010, 12'h040, 4, 3);
    repeat (5) @(posedge clk);
    #1 gnt_force = 0;
    repeat (5) @(posedge clk);
    #1 gnt_force = 1;
    wait_done();
    check("stall_span", last_v - first_v, 16);
    start_frame(12'hFFE, 12'h123, 4, 1);
    wait_done();
    start_frame(12'h100, 12'h010, 0, 3);
    wait_done();
    start_frame(12'h100, 12'h010, 3, 0);
    wait_done();
`ifdef CHIRP_FETCH_GAP_EN
    begin
      logic [7:0] pat = '0;
      gap_cyc = 3;
      start_frame(12'h200, 12'h020, 2, 2);
      for (int i = 0; i < 8; i++) begin
        pat = {pat[6:0], o_ram_rd_en};
        @(posedge clk); #1;
      end
      check("gap_pattern", pat, 8'b11000110);
      wait_done();
      gap_cyc = 0;
    end
`endif
    // async reset mid-frame aborts with no done pulse
    start_frame(12'h300, 12'h080, 6, 3);
    repeat (8) @(posedge clk);
    #3 rst = 1;
    #1 check_reset_outputs();
    addr_q.delete(); exp_q.delete(); exp_done_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (6) @(posedge clk);
    #1 check("no_done_after_abort", done_cnt - d_base, 0);
    // randomized frames with random grant
    gnt_rand = 1;
    for (int k = 0; k < 10; k++) begin
      start_frame(AW'($urandom), AW'($urandom), $urandom_range(6, 1), $urandom_range(4, 1));
      wait_done();
    end
    gnt_rand = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
